// File: rtl/vending_machine_change.sv
// Vending machine coin collector with dime/nickel change dispenser.
// Coins are counted on their rising edge. Once the credit reaches PRICE, the
// machine vends one item and then pays back any excess one coin per cycle.
// candy, change_dime and change_nickle are registered pulses. Each pulse
// appears in the cycle after the VEND/CHANGE state that produced it, together
// with the already-reduced credit.
module vending_machine_change #(
    parameter int PRICE = 20,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             nickle,
    input  logic             dime,
    input  logic             quarter,
    input  logic             cancel,
    output logic [WIDTH-1:0] num,
    output logic             candy,
    output logic             change_nickle,
    output logic             change_dime,
    output logic             busy
);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] VEND    = 2'd1;
    localparam logic [1:0] CHANGE  = 2'd2;

    localparam logic [WIDTH-1:0] PRICE_C = WIDTH'(PRICE);
    localparam logic [WIDTH-1:0] V5      = WIDTH'(5);
    localparam logic [WIDTH-1:0] V10     = WIDTH'(10);
    localparam logic [WIDTH-1:0] V25     = WIDTH'(25);

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] num_nx;
    logic             candy_nx, cn_nx, cd_nx;

    logic             nickle_q, dime_q, quarter_q;
    logic             ev_n, ev_d, ev_q;
    logic [1:0]       ev_count;
    logic             single_ev;
    logic [WIDTH-1:0] coin_val;

    // Previous-value registers for coin edge detection (always tracking, even while busy)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nickle_q  <= 1'b0;
            dime_q    <= 1'b0;
            quarter_q <= 1'b0;
        end else begin
            nickle_q  <= nickle;
            dime_q    <= dime;
            quarter_q <= quarter;
        end
    end

    assign ev_n      = nickle  & ~nickle_q;
    assign ev_d      = dime    & ~dime_q;
    assign ev_q      = quarter & ~quarter_q;
    assign ev_count  = {1'b0, ev_n} + {1'b0, ev_d} + {1'b0, ev_q};
    assign single_ev = (ev_count == 2'd1);
    assign busy      = (state != COLLECT);

    // Value of the single coin event in this cycle (zero if none or ambiguous)
    always_comb begin
        coin_val = '0;
        if (single_ev) begin
            if (ev_n)      coin_val = V5;
            else if (ev_d) coin_val = V10;
            else           coin_val = V25;
        end
    end

    // Next-state, next-credit and output-pulse decode
    always_comb begin
        state_nx = state;
        num_nx   = num;
        candy_nx = 1'b0;
        cn_nx    = 1'b0;
        cd_nx    = 1'b0;
        case (state)
            COLLECT: begin
                // A live cancel pre-empts any coin arriving in the same cycle
                if (cancel && (num != '0)) begin
                    state_nx = CHANGE;
                end else if (single_ev) begin
                    num_nx = num + coin_val;
                    if (num_nx >= PRICE_C) state_nx = VEND;
                end
            end
            VEND: begin
                candy_nx = 1'b1;
                num_nx   = num - PRICE_C;
                state_nx = (num_nx != '0) ? CHANGE : COLLECT;
            end
            CHANGE: begin
                if (num >= V10) begin
                    cd_nx  = 1'b1;
                    num_nx = num - V10;
                end else if (num >= V5) begin
                    cn_nx  = 1'b1;
                    num_nx = num - V5;
                end else begin
                    num_nx = '0;
                end
                if (num_nx == '0) state_nx = COLLECT;
            end
            default: begin
                state_nx = COLLECT;
                num_nx   = '0;
            end
        endcase
    end

    // State, credit and registered output pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= COLLECT;
            num           <= '0;
            candy         <= 1'b0;
            change_nickle <= 1'b0;
            change_dime   <= 1'b0;
        end else begin
            state         <= state_nx;
            num           <= num_nx;
            candy         <= candy_nx;
            change_nickle <= cn_nx;
            change_dime   <= cd_nx;
        end
    end

endmodule

// File: tb/tb_vending_machine_change.sv
// Directed testbench for vending_machine_change (PRICE=20, WIDTH=6).
// Each vector drives inputs, advances one clock, and checks the outputs 1ns after the edge.
module tb_vending_machine_change;

    localparam int PRICE = 20;
    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             nickle = 1'b0, dime = 1'b0, quarter = 1'b0, cancel = 1'b0;
    logic [WIDTH-1:0] num;
    logic             candy, change_nickle, change_dime, busy;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    typedef struct {
        string       name;
        logic        n, d, q, c;
        int unsigned num;
        logic        candy, cn, cd, busy;
    } vec_t;

    vec_t vecs[$];

    vending_machine_change #(.PRICE(PRICE), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .nickle(nickle), .dime(dime), .quarter(quarter), .cancel(cancel),
        .num(num), .candy(candy),
        .change_nickle(change_nickle), .change_dime(change_dime), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int unsigned e_num, input logic e_candy,
                           input logic e_cn, input logic e_cd, input logic e_busy);
        chk({nm, " num"},   32'(num),           32'(e_num));
        chk({nm, " candy"}, 32'(candy),         32'(e_candy));
        chk({nm, " cn"},    32'(change_nickle), 32'(e_cn));
        chk({nm, " cd"},    32'(change_dime),   32'(e_cd));
        chk({nm, " busy"},  32'(busy),          32'(e_busy));
    endtask

    task automatic add(input string nm, input logic n, input logic d, input logic q, input logic c,
                       input int unsigned e_num, input logic e_candy, input logic e_cn,
                       input logic e_cd, input logic e_busy);
        vec_t v;
        v.name = nm; v.n = n; v.d = d; v.q = q; v.c = c;
        v.num = e_num; v.candy = e_candy; v.cn = e_cn; v.cd = e_cd; v.busy = e_busy;
        vecs.push_back(v);
    endtask

    initial begin
        //   name          n  d  q  c   num candy cn cd busy
        add("n5",          1, 0, 0, 0,   5, 0, 0, 0, 0);
        add("n5_idle",     0, 0, 0, 0,   5, 0, 0, 0, 0);
        add("d15",         0, 1, 0, 0,  15, 0, 0, 0, 0);
        add("d15_hold",    0, 1, 0, 0,  15, 0, 0, 0, 0);
        add("cancel15",    0, 0, 0, 1,  15, 0, 0, 0, 1);
        add("refund_d",    0, 0, 0, 0,   5, 0, 0, 1, 1);
        add("refund_n",    0, 0, 0, 0,   0, 0, 1, 0, 0);
        add("cancel0",     0, 0, 0, 1,   0, 0, 0, 0, 0);
        add("cancel0_b",   0, 0, 0, 0,   0, 0, 0, 0, 0);
        add("dd_1",        0, 1, 0, 0,  10, 0, 0, 0, 0);
        add("dd_gap",      0, 0, 0, 0,  10, 0, 0, 0, 0);
        add("dd_2",        0, 1, 0, 0,  20, 0, 0, 0, 1);
        add("dd_vend",     0, 0, 0, 0,   0, 1, 0, 0, 0);
        add("dd_after",    0, 0, 0, 0,   0, 0, 0, 0, 0);
        add("dq_d",        0, 1, 0, 0,  10, 0, 0, 0, 0);
        add("dq_q",        0, 0, 1, 0,  35, 0, 0, 0, 1);
        add("dq_vend",     0, 0, 0, 0,  15, 1, 0, 0, 1);
        add("dq_cd",       0, 0, 0, 0,   5, 0, 0, 1, 1);
        add("dq_cn",       0, 0, 0, 0,   0, 0, 1, 0, 0);
        add("dq_done",     0, 0, 0, 0,   0, 0, 0, 0, 0);
        add("m_n",         1, 0, 0, 0,   5, 0, 0, 0, 0);
        add("m_gap",       0, 0, 0, 0,   5, 0, 0, 0, 0);
        add("m_nd_same",   1, 1, 0, 0,   5, 0, 0, 0, 0);
        add("m_gap2",      0, 0, 0, 0,   5, 0, 0, 0, 0);
        add("qh_1",        0, 0, 1, 0,  30, 0, 0, 0, 1);
        add("qh_2",        0, 0, 1, 0,  10, 1, 0, 0, 1);
        add("qh_3",        0, 0, 1, 0,   0, 0, 0, 1, 0);
        add("qh_4",        0, 0, 1, 0,   0, 0, 0, 0, 0);
        add("qh_5",        0, 0, 1, 0,   0, 0, 0, 0, 0);
        add("qh_rel",      0, 0, 0, 0,   0, 0, 0, 0, 0);
        add("cc_d",        0, 1, 0, 0,  10, 0, 0, 0, 0);
        add("cc_both",     1, 0, 0, 1,  10, 0, 0, 0, 1);
        add("cc_cd",       0, 0, 0, 0,   0, 0, 0, 1, 0);
        add("bz_d",        0, 1, 0, 0,  10, 0, 0, 0, 0);
        add("bz_q",        0, 0, 1, 0,  35, 0, 0, 0, 1);
        add("bz_n_busy",   1, 0, 0, 0,  15, 1, 0, 0, 1);
        add("bz_cd",       0, 0, 0, 0,   5, 0, 0, 1, 1);
        add("bz_cn",       0, 0, 0, 0,   0, 0, 1, 0, 0);
        add("bz_done",     0, 0, 0, 0,   0, 0, 0, 0, 0);
        add("mx_d",        0, 1, 0, 0,  10, 0, 0, 0, 0);
        add("mx_n",        1, 0, 0, 0,  15, 0, 0, 0, 0);
        add("mx_q40",      0, 0, 1, 0,  40, 0, 0, 0, 1);
        add("mx_vend",     0, 0, 0, 0,  20, 1, 0, 0, 1);
        add("mx_cd1",      0, 0, 0, 0,  10, 0, 0, 1, 1);
        add("mx_cd2",      0, 0, 0, 0,   0, 0, 0, 1, 0);
        add("mx_done",     0, 0, 0, 0,   0, 0, 0, 0, 0);

        // Reset state
        step();
        chk_all("reset_low", 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        chk_all("reset_rel", 0, 0, 0, 0, 0);

        // Table-driven main sequence
        foreach (vecs[i]) begin
            nickle = vecs[i].n; dime = vecs[i].d; quarter = vecs[i].q; cancel = vecs[i].c;
            step();
            chk_all(vecs[i].name, vecs[i].num, vecs[i].candy, vecs[i].cn, vecs[i].cd, vecs[i].busy);
        end
        nickle = 0; dime = 0; quarter = 0; cancel = 0;

        // Asynchronous reset in the middle of a refund
        quarter = 1'b1;
        step();
        chk_all("ar_q", 25, 0, 0, 0, 1);
        quarter = 1'b0;
        step();
        chk_all("ar_vend", 5, 1, 0, 0, 1);
        #2 reset = 1'b0;
        #1 chk_all("ar_async", 0, 0, 0, 0, 0);
        step();
        chk_all("ar_held", 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        chk_all("ar_post1", 0, 0, 0, 0, 0);
        step();
        chk_all("ar_post2", 0, 0, 0, 0, 0);

        // Coin already high when reset releases counts exactly once
        #2 reset = 1'b0;
        nickle = 1'b1;
        step();
        chk_all("pre_low", 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        chk_all("pre_first", 5, 0, 0, 0, 0);
        step();
        chk_all("pre_held", 5, 0, 0, 0, 0);
        nickle = 1'b0;
        step();
        chk_all("pre_rel", 5, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
